hld_div_ctrl: RTL and testbench

//   Drives the DIV_M strobe and the M mode select into the hold-control logic of the FMDLL.
//   A programmable modulo-N counter runs on the DLL control clock and emits one DIV_M pulse per frame.
//   New N and M values are applied only at frame boundaries, followed by one blanking cycle.

---
 rtl/hld_div_ctrl.sv | 109 ++++++++++
 tb/tb_hld_div_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hld_div_ctrl.sv
// hld_div_ctrl: modulo-N DIV_M frame strobe and M select with glitch-free reconfiguration at frame boundaries
module hld_div_ctrl #(
  parameter int CNT_W        = 6,
  parameter int N_DEFAULT    = 4,
  parameter bit MODE_DEFAULT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_load,
  input  logic [CNT_W-1:0] cfg_n,
  input  logic             cfg_mode,
  output logic             DIV_M,
  output logic             M,
  output logic [CNT_W-1:0] phase,
  output logic             frame_tog,
  output logic             cfg_ack,
  output logic             cfg_err
);
  typedef enum logic [1:0] {IDLE, RUN, SWITCH} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, n_act_q, n_act_d, pend_n_q, pend_n_d;
  logic m_q, m_d, pend_q, pend_d, pend_mode_q, pend_mode_d;
  logic tog_q, tog_d, div_q, div_d, ack_q, ack_d, err_q, err_d;
  logic load_ok, wrap;
  always_comb begin
    load_ok     = cfg_load && (cfg_n >= CNT_W'(2));
    wrap        = (state_q == RUN) && (cnt_q == n_act_q - CNT_W'(1));
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_act_d     = n_act_q;
    m_d         = m_q;
    pend_d      = pend_q;
    pend_n_d    = pend_n_q;
    pend_mode_d = pend_mode_q;
    tog_d       = tog_q;
    ack_d       = 1'b0;
    err_d       = cfg_load && !load_ok;
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        state_d = en ? RUN : IDLE;
        if (load_ok) begin
          n_act_d = cfg_n;
          m_d     = cfg_mode;
          pend_d  = 1'b0;
          ack_d   = 1'b1;
        end
      end
      RUN: begin
        cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
        tog_d = tog_q ^ wrap;
        if (wrap && pend_q) begin
          state_d = SWITCH;
          n_act_d = pend_n_q;
          m_d     = pend_mode_q;
          pend_d  = 1'b0;
          ack_d   = 1'b1;
        end else if (wrap && !en) begin
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = en ? RUN : IDLE;
      end
    endcase
    // a load outside IDLE always becomes (or replaces) the pending config
    if (load_ok && state_q != IDLE) begin
      pend_d      = 1'b1;
      pend_n_d    = cfg_n;
      pend_mode_d = cfg_mode;
    end
    div_d = (state_d == RUN) && (cnt_d == n_act_d - CNT_W'(1));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      n_act_q     <= CNT_W'(N_DEFAULT);
      m_q         <= MODE_DEFAULT;
      pend_q      <= 1'b0;
      pend_n_q    <= '0;
      pend_mode_q <= 1'b0;
      tog_q       <= 1'b0;
      div_q       <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_act_q     <= n_act_d;
      m_q         <= m_d;
      pend_q      <= pend_d;
      pend_n_q    <= pend_n_d;
      pend_mode_q <= pend_mode_d;
      tog_q       <= tog_d;
      div_q       <= div_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
    end
  end
  assign DIV_M     = div_q;
  assign M         = m_q;
  assign phase     = cnt_q;
  assign frame_tog = tog_q;
  assign cfg_ack   = ack_q;
  assign cfg_err   = err_q;
endmodule

// File: tb/tb_hld_div_ctrl.sv
// tb_hld_div_ctrl: scoreboard bench for hld_div_ctrl frame timing and reconfiguration
module tb_hld_div_ctrl;
  typedef struct packed {
    logic       div;
    logic       m;
    logic [5:0] ph;
    logic       tog;
    logic       ack;
    logic       err;
  } obs_t;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, cfg_load = 1'b0, cfg_mode = 1'b0;
  logic [5:0] cfg_n = '0;
  logic DIV_M, M, frame_tog, cfg_ack, cfg_err;
  logic [5:0] phase;
  obs_t exp_q[$], act_q[$];
  obs_t e, a;
  int n_chk = 0, n_fail = 0;
  int e_ph = 0, e_n = 4;
  logic e_m = 1'b0, e_tog = 1'b0;
  hld_div_ctrl #(.CNT_W(6), .N_DEFAULT(4), .MODE_DEFAULT(1'b0)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_load(cfg_load), .cfg_n(cfg_n), .cfg_mode(cfg_mode),
    .DIV_M(DIV_M), .M(M), .phase(phase), .frame_tog(frame_tog), .cfg_ack(cfg_ack), .cfg_err(cfg_err)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
    act_q.push_back(obs_t'({DIV_M, M, phase, frame_tog, cfg_ack, cfg_err}));
    cfg_load = 1'b0;
  endtask
  task automatic load(input int n, input logic mode);
    cfg_n    = 6'(n);
    cfg_mode = mode;
    cfg_load = 1'b1;
  endtask
  // expectation for the next cycle of an uninterrupted RUN frame
  task automatic exp_step(input logic ack, input logic err);
    if (e_ph == e_n - 1) begin
      e_ph  = 0;
      e_tog = ~e_tog;
    end else e_ph++;
    exp_q.push_back(obs_t'({logic'(e_ph == e_n - 1), e_m, 6'(e_ph), e_tog, ack, err}));
  endtask
  task automatic push_zero(input logic ack);
    e_ph = 0;
    exp_q.push_back(obs_t'({1'b0, e_m, 6'd0, e_tog, ack, 1'b0}));
  endtask
  task automatic push_switch(input int n, input logic m);
    e_tog = ~e_tog;
    e_n   = n;
    e_m   = m;
    push_zero(1'b1);
  endtask
  task automatic steady_to(input int ph);
    while (e_ph != ph) begin
      exp_step(1'b0, 1'b0);
      tick();
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b0;
    repeat (2) begin
      push_zero(1'b0);
      tick();
    end
    rst = 1'b0;
    push_zero(1'b0);
    tick();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL reset: got %b required %b", a, e);
      end
    end
  endtask
  task automatic test_run();
    en = 1'b1;
    push_zero(1'b0);
    tick();
    repeat (12) begin
      exp_step(1'b0, 1'b0);
      tick();
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL run: got %b required %b", a, e);
      end
    end
  endtask
  task automatic test_switch();
    steady_to(1);
    load(6, 1'b1);
    steady_to(3);
    push_switch(6, 1'b1);
    tick();
    push_zero(1'b0);
    tick();
    repeat (14) begin
      exp_step(1'b0, 1'b0);
      tick();
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL switch: got %b required %b", a, e);
      end
    end
  endtask
  task automatic test_cfg_err();
    steady_to(2);
    load(1, 1'b0);
    exp_step(1'b0, 1'b1);
    tick();
    steady_to(5);
    load(0, 1'b0);
    exp_step(1'b0, 1'b1);
    tick();
    repeat (12) begin
      exp_step(1'b0, 1'b0);
      tick();
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL cfg_err: got %b required %b", a, e);
      end
    end
  endtask
  task automatic test_last_wins();
    steady_to(1);
    load(5, 1'b0);
    exp_step(1'b0, 1'b0);
    tick();
    load(7, 1'b0);
    steady_to(5);
    push_switch(7, 1'b0);
    tick();
    push_zero(1'b0);
    tick();
    repeat (16) begin
      exp_step(1'b0, 1'b0);
      tick();
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL last_wins: got %b required %b", a, e);
      end
    end
  endtask
  task automatic test_rst_mid();
    steady_to(1);
    load(3, 1'b1);
    steady_to(2);
    rst   = 1'b1;
    e_tog = 1'b0;
    e_m   = 1'b0;
    e_n   = 4;
    push_zero(1'b0);
    tick();
    rst = 1'b0;
    en  = 1'b0;
    repeat (2) begin
      push_zero(1'b0);
      tick();
    end
    en = 1'b1;
    push_zero(1'b0);
    tick();
    repeat (13) begin
      exp_step(1'b0, 1'b0);
      tick();
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL rst_mid: got %b required %b", a, e);
      end
    end
  endtask
  task automatic test_stop_idle_load();
    steady_to(1);
    en = 1'b0;
    steady_to(3);
    e_tog = ~e_tog;
    repeat (3) begin
      push_zero(1'b0);
      tick();
    end
    load(3, 1'b1);
    e_n = 3;
    e_m = 1'b1;
    push_zero(1'b1);
    tick();
    en = 1'b1;
    load(5, 1'b0);
    e_n = 5;
    e_m = 1'b0;
    push_zero(1'b1);
    tick();
    repeat (11) begin
      exp_step(1'b0, 1'b0);
      tick();
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL stop_idle_load: got %b required %b", a, e);
      end
    end
  endtask
  task automatic test_back_to_back();
    steady_to(4);
    load(3, 1'b1);
    exp_step(1'b0, 1'b0);
    tick();
    steady_to(4);
    push_switch(3, 1'b1);
    tick();
    push_zero(1'b0);
    tick();
    load(4, 1'b0);
    steady_to(2);
    load(2, 1'b1);
    push_switch(4, 1'b0);
    tick();
    push_zero(1'b0);
    tick();
    steady_to(3);
    push_switch(2, 1'b1);
    tick();
    push_zero(1'b0);
    tick();
    repeat (8) begin
      exp_step(1'b0, 1'b0);
      tick();
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL back_to_back: got %b required %b", a, e);
      end
    end
  endtask
  initial begin
    test_reset();
    test_run();
    test_switch();
    test_cfg_err();
    test_last_wins();
    test_rst_mid();
    test_stop_idle_load();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
